// File: rtl/legn_core.sv
// legn_core -- parametrised single-cycle accumulator-style CPU core.
//
// One instruction is fetched and retired on every rising clock edge while
// the core is in RUN. The program ROM is external and combinational: the
// core drives adr and expects the matching instruction word on instr in
// the same cycle.
//
// Instruction word: {op[3:0], imm[W-1:0]}.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous, active-high reset
//   instr    instruction word read from the ROM at adr
//   in       external input port, sampled into in_r on every edge
//   resume   leaves HALTED at the next edge (ignored while running)
//   adr      program counter
//   a, b     general registers
//   out      output port register
//   carry    carry flag (set only by the two ADD instructions)
//   zero     zero flag (tracks the last value written to A or B)
//   halted   high while in the HALTED state
//   stk_err  sticky return-stack overflow/underflow flag
module legn_core #(
  parameter int W           = 4,
  parameter int STACK_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W+3:0] instr,
  input  logic [W-1:0] in,
  input  logic         resume,
  output logic [W-1:0] adr,
  output logic [W-1:0] a,
  output logic [W-1:0] b,
  output logic [W-1:0] out,
  output logic         carry,
  output logic         zero,
  output logic         halted,
  output logic         stk_err
);

  // The stack pointer counts occupied entries, so it needs to reach
  // STACK_DEPTH itself (full), not just STACK_DEPTH-1.
  localparam int SP_W = $clog2(STACK_DEPTH + 1);
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  // All sixteen encodings are meaningful, so there is no illegal opcode.
  typedef enum logic [3:0] {
    OP_ADD_A   = 4'b0000,
    OP_MOV_AB  = 4'b0001,
    OP_IN_A    = 4'b0010,
    OP_MOV_AI  = 4'b0011,
    OP_MOV_BA  = 4'b0100,
    OP_ADD_B   = 4'b0101,
    OP_IN_B    = 4'b0110,
    OP_MOV_BI  = 4'b0111,
    OP_CALL    = 4'b1000,
    OP_OUT_B   = 4'b1001,
    OP_RET     = 4'b1010,
    OP_OUT_I   = 4'b1011,
    OP_JZ      = 4'b1100,
    OP_HALT    = 4'b1101,
    OP_JNC     = 4'b1110,
    OP_JMP     = 4'b1111
  } op_t;

  typedef enum logic {
    S_RUN    = 1'b0,
    S_HALTED = 1'b1
  } state_t;

  // Architectural state
  state_t          state_reg, state_next;
  logic [W-1:0]    a_reg, a_next;
  logic [W-1:0]    b_reg, b_next;
  logic [W-1:0]    out_reg, out_next;
  logic [W-1:0]    adr_reg, adr_next;
  logic            carry_reg, carry_next;
  logic            zero_reg, zero_next;
  logic            err_reg, err_next;
  logic [SP_W-1:0] sp_reg, sp_next;
  logic [W-1:0]    in_r;

  // Return stack storage; entry i is valid when sp_reg > i.
  logic [W-1:0]    stack_mem [STACK_DEPTH];

  // Decode / datapath helpers
  op_t             op;
  logic [W-1:0]    imm;
  logic [W-1:0]    adr_plus1;
  logic [W:0]      sum_a;
  logic [W:0]      sum_b;
  logic [W-1:0]    pop_data;
  logic            push_en;
  logic            stack_full;
  logic            stack_empty;

  assign op          = op_t'(instr[W+3:W]);
  assign imm         = instr[W-1:0];
  assign adr_plus1   = adr_reg + W'(1);   // wraps naturally at 2^W
  assign sum_a       = {1'b0, a_reg} + {1'b0, imm};
  assign sum_b       = {1'b0, b_reg} + {1'b0, imm};
  assign stack_full  = (sp_reg == SP_FULL);
  assign stack_empty = (sp_reg == '0);

  // Top-of-stack read: select the entry just below the pointer.
  always_comb begin
    pop_data = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (sp_reg == SP_W'(i + 1)) begin
        pop_data = stack_mem[i];
      end
    end
  end

  // Next-state / datapath logic
  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    out_next   = out_reg;
    adr_next   = adr_reg;
    carry_next = carry_reg;
    zero_next  = zero_reg;
    err_next   = err_reg;
    sp_next    = sp_reg;
    push_en    = 1'b0;

    unique case (state_reg)
      S_RUN: begin
        // Only the ADDs produce a carry; everything else clears it, so a
        // JNC always looks at the instruction immediately before it.
        carry_next = 1'b0;
        adr_next   = adr_plus1;

        unique case (op)
          OP_ADD_A: begin
            a_next     = sum_a[W-1:0];
            carry_next = sum_a[W];
            zero_next  = (sum_a[W-1:0] == '0);
          end
          OP_ADD_B: begin
            b_next     = sum_b[W-1:0];
            carry_next = sum_b[W];
            zero_next  = (sum_b[W-1:0] == '0);
          end
          OP_MOV_AI: begin
            a_next    = imm;
            zero_next = (imm == '0);
          end
          OP_MOV_BI: begin
            b_next    = imm;
            zero_next = (imm == '0);
          end
          OP_MOV_AB: begin
            a_next    = b_reg;
            zero_next = (b_reg == '0);
          end
          OP_MOV_BA: begin
            b_next    = a_reg;
            zero_next = (a_reg == '0);
          end
          OP_IN_A: begin
            a_next    = in_r;
            zero_next = (in_r == '0);
          end
          OP_IN_B: begin
            b_next    = in_r;
            zero_next = (in_r == '0);
          end
          OP_OUT_B: begin
            out_next = b_reg;
          end
          OP_OUT_I: begin
            out_next = imm;
          end
          OP_JMP: begin
            adr_next = imm;
          end
          OP_JNC: begin
            if (!carry_reg) adr_next = imm;
          end
          OP_JZ: begin
            if (zero_reg) adr_next = imm;
          end
          OP_CALL: begin
            // A full stack turns CALL into a flagged no-op that falls through.
            if (stack_full) begin
              err_next = 1'b1;
            end else begin
              push_en  = 1'b1;
              sp_next  = sp_reg + SP_W'(1);
              adr_next = imm;
            end
          end
          OP_RET: begin
            // An empty stack turns RET into a flagged no-op that falls through.
            if (stack_empty) begin
              err_next = 1'b1;
            end else begin
              sp_next  = sp_reg - SP_W'(1);
              adr_next = pop_data;
            end
          end
          OP_HALT: begin
            state_next = S_HALTED;
          end
          default: begin
          end
        endcase
      end

      S_HALTED: begin
        // Everything holds; the resume edge itself executes nothing, so
        // the instruction at adr runs on the edge after it.
        if (resume) state_next = S_RUN;
      end

      default: begin
        state_next = S_RUN;
      end
    endcase
  end

  // Architectural registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_RUN;
      a_reg     <= '0;
      b_reg     <= '0;
      out_reg   <= '0;
      adr_reg   <= '0;
      carry_reg <= 1'b0;
      zero_reg  <= 1'b0;
      err_reg   <= 1'b0;
      sp_reg    <= '0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      out_reg   <= out_next;
      adr_reg   <= adr_next;
      carry_reg <= carry_next;
      zero_reg  <= zero_next;
      err_reg   <= err_next;
      sp_reg    <= sp_next;
    end
  end

  // Input port sampler runs regardless of RUN/HALTED, so IN sees the
  // value that was on the pins one cycle earlier.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_r <= '0;
    end else begin
      in_r <= in;
    end
  end

  // Stack entries need no reset: the pointer alone says which are valid.
  genvar gi;
  generate
    for (gi = 0; gi < STACK_DEPTH; gi++) begin : g_stack
      always_ff @(posedge clk) begin
        if (push_en && (sp_reg == SP_W'(gi))) begin
          stack_mem[gi] <= adr_plus1;
        end
      end
    end
  endgenerate

  assign adr     = adr_reg;
  assign a       = a_reg;
  assign b       = b_reg;
  assign out     = out_reg;
  assign carry   = carry_reg;
  assign zero    = zero_reg;
  assign halted  = (state_reg == S_HALTED);
  assign stk_err = err_reg;

endmodule
